wb_traffic_gen: RTL and testbench
=================================

# wb_traffic_gen

Pipelined Wishbone B4 initiator that issues a programmable run of single-word writes or reads and self-checks read data against a seed-based pattern. Its bus port connects to one master port of the system crossbar (AW=28, DW=32). It stresses and verifies the crossbar's slave-side routing, stall and ack paths from the initiator end. Intended as a bring-up and BIST engine driven by a CSR block or a testbench.

## Interface
- AW, 28, word-address width (matches crossbar AW)
- DW, 32, data width; o_sel width is DW/8
- LW, 16, width of the length and error-count fields

- i_clk  in  1  clock, all logic rising-edge
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  start pulse, honoured only in IDLE
- i_we  in  1  run direction: 1 = write run, 0 = read-and-check run
- i_base  in  AW  first word address
- i_len  in  LW  number of transfers; 0 is legal
- i_seed  in  DW  pattern seed
- o_busy  out  1  run in progress
- o_done  out  1  one-cycle pulse at run end
- o_nerr  out  LW  read-data mismatch count, saturating
- o_buserr  out  1  run ended by i_err
- o_cyc, o_stb, o_we  out  1 each  Wishbone master controls
- o_addr  out  AW  word address
- o_data  out  DW  write data
- o_sel  out  DW/8  byte selects
- i_stall, i_ack, i_err  in  1 each  Wishbone slave responses
- i_data  in  DW  read data

## Operation
- All outputs are registered. Reset value of every output is 0.
- States: IDLE, ISSUE, DRAIN.
- IDLE, i_start=1, i_len≠0:
  - latch i_we, i_base, i_len, i_seed
  - clear o_nerr and o_buserr; clear issue counter `iss` and ack counter `ack`
  - assert o_cyc, o_stb and o_busy; o_we = i_we; o_addr = i_base
  - o_data = i_seed when writing, else 0; o_sel = all ones
  - go to ISSUE
- IDLE, i_start=1, i_len=0: clear o_nerr and o_buserr, pulse o_done, issue no bus cycle, stay in IDLE.
- ISSUE: a request is accepted in each cycle where o_stb=1 and i_stall=0. On acceptance:
  - iss++
  - o_addr++ (wraps modulo 2^AW)
  - write data for the next beat = seed + iss (modulo 2^DW)
  - when iss reaches len, drop o_stb and go to DRAIN, with o_cyc still high
  - while i_stall=1, o_stb, o_addr and o_data hold
- Ack handling, in ISSUE or DRAIN: an i_ack is counted only while ack < iss.
  - read runs compare i_data with seed + ack; on mismatch o_nerr increments and saturates at 2^LW−1
  - when ack reaches len: drop o_cyc and o_busy, pulse o_done, go to IDLE
  - ISSUE can complete directly if the final ack and final acceptance coincide
- i_err with o_cyc=1, in any state: abort the run.
  - next cycle: o_cyc=0, o_stb=0, o_busy=0, o_buserr=1, o_done=1; go to IDLE
  - acks still outstanding are discarded
  - i_err takes priority over an i_ack in the same cycle
- i_ack and i_err are ignored while o_cyc=0. i_start is ignored while busy.
- o_nerr and o_buserr hold their values after the run until the next start.
- Asynchronous reset mid-run drops o_cyc and o_stb immediately, returns to IDLE, and produces no o_done.

## Timing
- i_start sampled at edge 0 → o_cyc and o_stb high from cycle 1. Back-to-back acceptance gives one transfer per cycle.
- Final acceptance at edge N → o_stb=0 in cycle N+1.
- Final counted ack at edge M → o_cyc=0, o_busy=0 and o_done=1 in cycle M+1. o_done is 0 in M+2.
- i_err at edge E → abort outputs as above in cycle E+1.
- Zero-length start at edge 0 → o_done=1 in cycle 1; o_busy stays 0.
- A new start is accepted on the edge where o_done=1 is visible, since the block is already in IDLE.
- No combinational path from any input to any output.

## Test plan
- Write, base=0x0000100, len=4, seed=0xA5A50000, no stall, ack one cycle after stb:
  - o_addr = 0x100..0x103 on 4 consecutive cycles; o_data = 0xA5A50000..0xA5A50003
  - o_done one cycle after the 4th ack; o_nerr=0
- Read, len=4, seed=0x10, slave returns 0x10, 0x11, 0x99, 0x13 → o_nerr=1, o_buserr=0, one o_done pulse.
- Write, len=3, i_stall high for 2 cycles on the 2nd beat:
  - o_addr and o_data hold during the stall
  - exactly 3 accepted beats; o_stb drops the cycle after the 3rd acceptance
- Read, len=8, i_err on the 3rd response:
  - o_cyc=0 and o_buserr=1 next cycle
  - later acks ignored; o_nerr counts only the first 2 beats
- Edge cases:
  - i_len=0 → o_done at cycle 1 with no o_cyc
  - base=0xFFFFFFF, len=2 → o_addr 0xFFFFFFF then 0x0000000
  - i_start during a run is ignored
- Assert i_reset mid-run with 2 acks outstanding:
  - all outputs 0 immediately; no o_done
  - a fresh run after reset completes normally

Source files
------------

// File: rtl/wb_traffic_gen.sv
// wb_traffic_gen: pipelined Wishbone B4 initiator for crossbar bring-up / BIST.
// Issues a run of i_len single-word writes or reads starting at i_base. Write
// data and expected read data both follow the pattern seed + beat index.
// Ports:
//   i_clk, i_reset            clock, async active-high reset
//   i_start, i_we, i_base,
//   i_len, i_seed             run control (sampled only in IDLE)
//   o_busy, o_done, o_nerr,
//   o_buserr                  run status
//   o_cyc..o_sel, i_stall,
//   i_ack, i_err, i_data      Wishbone master port
module wb_traffic_gen #(
    parameter int AW = 28,
    parameter int DW = 32,
    parameter int LW = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_we,
    input  logic [AW-1:0]   i_base,
    input  logic [LW-1:0]   i_len,
    input  logic [DW-1:0]   i_seed,
    output logic            o_busy,
    output logic            o_done,
    output logic [LW-1:0]   o_nerr,
    output logic            o_buserr,
    output logic            o_cyc,
    output logic            o_stb,
    output logic            o_we,
    output logic [AW-1:0]   o_addr,
    output logic [DW-1:0]   o_data,
    output logic [DW/8-1:0] o_sel,
    input  logic            i_stall,
    input  logic            i_ack,
    input  logic            i_err,
    input  logic [DW-1:0]   i_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state;
    logic          we_r;
    logic [LW-1:0] len_r;
    logic [DW-1:0] seed_r;
    logic [LW-1:0] iss;     // requests accepted so far
    logic [LW-1:0] ack;     // responses counted so far

    logic          accept;
    logic          ack_hit;
    logic          mismatch;
    logic [LW-1:0] iss_nx;
    logic [LW-1:0] ack_nx;

    assign accept   = (state == ISSUE) && o_stb && !i_stall;
    // Only count acks for requests actually issued; stray acks are dropped.
    assign ack_hit  = o_cyc && i_ack && (ack < iss);
    assign iss_nx   = iss + LW'(1);
    assign ack_nx   = ack + LW'(1);
    assign mismatch = (i_data != (seed_r + DW'(ack)));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            we_r     <= 1'b0;
            len_r    <= '0;
            seed_r   <= '0;
            iss      <= '0;
            ack      <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_nerr   <= '0;
            o_buserr <= 1'b0;
            o_cyc    <= 1'b0;
            o_stb    <= 1'b0;
            o_we     <= 1'b0;
            o_addr   <= '0;
            o_data   <= '0;
            o_sel    <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_nerr   <= '0;
                        o_buserr <= 1'b0;
                        if (i_len == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            we_r   <= i_we;
                            len_r  <= i_len;
                            seed_r <= i_seed;
                            iss    <= '0;
                            ack    <= '0;
                            o_cyc  <= 1'b1;
                            o_stb  <= 1'b1;
                            o_busy <= 1'b1;
                            o_we   <= i_we;
                            o_addr <= i_base;
                            o_data <= i_we ? i_seed : '0;
                            o_sel  <= '1;
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE, DRAIN: begin
                    if (o_cyc && i_err) begin
                        // Abort: outstanding responses are abandoned with the cycle.
                        o_cyc    <= 1'b0;
                        o_stb    <= 1'b0;
                        o_busy   <= 1'b0;
                        o_we     <= 1'b0;
                        o_sel    <= '0;
                        o_buserr <= 1'b1;
                        o_done   <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        if (accept) begin
                            iss    <= iss_nx;
                            o_addr <= o_addr + AW'(1);
                            if (we_r) o_data <= seed_r + DW'(iss_nx);
                            if (iss_nx == len_r) begin
                                o_stb <= 1'b0;
                                state <= DRAIN;
                            end
                        end
                        if (ack_hit) begin
                            ack <= ack_nx;
                            if (!we_r && mismatch && (o_nerr != '1))
                                o_nerr <= o_nerr + LW'(1);
                            // Completion overrides the DRAIN move above.
                            if (ack_nx == len_r) begin
                                o_cyc  <= 1'b0;
                                o_stb  <= 1'b0;
                                o_busy <= 1'b0;
                                o_we   <= 1'b0;
                                o_sel  <= '0;
                                o_done <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_traffic_gen.sv
// Directed bench for wb_traffic_gen with a one-cycle-latency pipelined slave.
module tb_wb_traffic_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_we;
    logic [27:0] i_base;
    logic [15:0] i_len;
    logic [31:0] i_seed;
    logic        o_busy, o_done, o_buserr, o_cyc, o_stb, o_we;
    logic [15:0] o_nerr;
    logic [27:0] o_addr;
    logic [31:0] o_data;
    logic [3:0]  o_sel;
    logic        i_stall, i_ack, i_err;
    logic [31:0] i_data;

    int errors = 0;
    int checks = 0;

    // slave model knobs
    logic [31:0] rd_data [0:15];
    int          resp_idx;
    int          err_at;
    int          acc_cnt;
    logic        noack;
    logic        acc_s;

    wb_traffic_gen dut (
        .i_clk(clk), .i_reset(rst), .i_start(i_start), .i_we(i_we),
        .i_base(i_base), .i_len(i_len), .i_seed(i_seed),
        .o_busy(o_busy), .o_done(o_done), .o_nerr(o_nerr), .o_buserr(o_buserr),
        .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr),
        .o_data(o_data), .o_sel(o_sel), .i_stall(i_stall), .i_ack(i_ack),
        .i_err(i_err), .i_data(i_data)
    );

    always #5 clk = ~clk;

    // Slave: a request accepted at an edge is answered during the next cycle.
    always @(posedge clk) begin
        acc_s = o_cyc && o_stb && !i_stall;
        #1;
        i_ack  = 1'b0;
        i_err  = 1'b0;
        i_data = '0;
        if (acc_s) begin
            acc_cnt++;
            if (!noack) begin
                if (resp_idx == err_at) i_err = 1'b1;
                else                    i_ack = 1'b1;
                i_data = rd_data[resp_idx % 16];
                resp_idx++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic slave_init();
        resp_idx = 0;
        err_at   = -1;
        acc_cnt  = 0;
        noack    = 1'b0;
        i_stall  = 1'b0;
        for (int i = 0; i < 16; i++) rd_data[i] = '0;
    endtask

    task automatic start_run(input logic we, input logic [27:0] base,
                             input logic [15:0] len, input logic [31:0] seed);
        i_we = we; i_base = base; i_len = len; i_seed = seed; i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Fixed window, so always bounded; returns number of o_done pulses seen.
    task automatic count_done(input int ncyc, output int nd);
        nd = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (o_done) nd++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 0; i_we = 0; i_base = '0; i_len = '0; i_seed = '0;
        slave_init();
        #3;
        checks++;
        if ({o_busy, o_done, o_nerr, o_buserr, o_cyc, o_stb, o_we, o_addr, o_data, o_sel} !== '0)
            begin $display("FAIL reset_outputs: got cyc=%b stb=%b busy=%b addr=%h data=%h want all 0",
                           o_cyc, o_stb, o_busy, o_addr, o_data); errors++; end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        logic [27:0] ea;
        logic [31:0] ed;
        slave_init();
        start_run(1'b1, 28'h0000100, 16'd4, 32'hA5A50000);
        for (int k = 0; k < 4; k++) begin
            ea = 28'h0000100 + 28'(k);
            ed = 32'hA5A50000 + 32'(k);
            checks++;
            if (o_addr !== ea) begin $display("FAIL wr_addr beat%0d: got %h want %h", k, o_addr, ea); errors++; end
            checks++;
            if (o_data !== ed) begin $display("FAIL wr_data beat%0d: got %h want %h", k, o_data, ed); errors++; end
            checks++;
            if ({o_cyc, o_stb, o_we, o_busy, o_sel} !== 8'b1111_1111)
                begin $display("FAIL wr_ctrl beat%0d: got cyc=%b stb=%b we=%b busy=%b sel=%h want 1,1,1,1,f",
                               k, o_cyc, o_stb, o_we, o_busy, o_sel); errors++; end
            tick();
        end
        checks++;
        if ({o_cyc, o_stb, o_done} !== 3'b100)
            begin $display("FAIL wr_drain: got cyc=%b stb=%b done=%b want 1,0,0", o_cyc, o_stb, o_done); errors++; end
        tick();
        checks++;
        if ({o_done, o_cyc, o_busy} !== 3'b100 || o_nerr !== 16'd0)
            begin $display("FAIL wr_done: got done=%b cyc=%b busy=%b nerr=%0d want 1,0,0,0",
                           o_done, o_cyc, o_busy, o_nerr); errors++; end
        tick();
        checks++;
        if (o_done !== 1'b0) begin $display("FAIL wr_done_pulse: got %b want 0", o_done); errors++; end
    endtask

    task automatic test_read_check();
        int nd;
        slave_init();
        rd_data[0] = 32'h10; rd_data[1] = 32'h11; rd_data[2] = 32'h99; rd_data[3] = 32'h13;
        start_run(1'b0, 28'h0000200, 16'd4, 32'h10);
        checks++;
        if ({o_we, o_data} !== 33'd0 || o_cyc !== 1'b1)
            begin $display("FAIL rd_first: got we=%b data=%h cyc=%b want 0,0,1", o_we, o_data, o_cyc); errors++; end
        count_done(12, nd);
        checks++;
        if (nd !== 1) begin $display("FAIL rd_done_count: got %0d want 1", nd); errors++; end
        checks++;
        if (o_nerr !== 16'd1 || o_buserr !== 1'b0)
            begin $display("FAIL rd_status: got nerr=%0d buserr=%b want 1,0", o_nerr, o_buserr); errors++; end
    endtask

    task automatic test_stall();
        slave_init();
        start_run(1'b1, 28'h0000300, 16'd3, 32'h50);
        tick();                     // cycle 2: beat 1 presented
        i_stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_addr !== 28'h0000301 || o_data !== 32'h51 || o_stb !== 1'b1)
                begin $display("FAIL stall_hold%0d: got addr=%h data=%h stb=%b want 301,51,1",
                               k, o_addr, o_data, o_stb); errors++; end
            tick();
        end
        i_stall = 1'b0;             // cycle 4: beat 1 accepted at next edge
        checks++;
        if (o_addr !== 28'h0000301) begin $display("FAIL stall_release: got %h want 301", o_addr); errors++; end
        tick();
        checks++;
        if (o_addr !== 28'h0000302 || o_data !== 32'h52 || o_stb !== 1'b1)
            begin $display("FAIL stall_beat2: got addr=%h data=%h stb=%b want 302,52,1", o_addr, o_data, o_stb); errors++; end
        tick();
        checks++;
        if ({o_stb, o_cyc} !== 2'b01)
            begin $display("FAIL stall_stb_drop: got stb=%b cyc=%b want 0,1", o_stb, o_cyc); errors++; end
        tick();
        checks++;
        if (o_done !== 1'b1 || acc_cnt !== 3)
            begin $display("FAIL stall_done: got done=%b accepted=%0d want 1,3", o_done, acc_cnt); errors++; end
    endtask

    task automatic test_bus_error();
        int nd;
        slave_init();
        rd_data[0] = 32'h1000; rd_data[1] = 32'h0BAD; rd_data[3] = 32'h0BAD;
        err_at = 2;
        start_run(1'b0, 28'h0000400, 16'd8, 32'h1000);
        tick(); tick(); tick();     // cycle 4: i_err on the 3rd response
        tick();
        checks++;
        if ({o_cyc, o_stb, o_busy, o_buserr, o_done} !== 5'b00011)
            begin $display("FAIL err_abort: got cyc=%b stb=%b busy=%b buserr=%b done=%b want 0,0,0,1,1",
                           o_cyc, o_stb, o_busy, o_buserr, o_done); errors++; end
        tick();
        count_done(5, nd);
        checks++;
        if (o_nerr !== 16'd1 || nd !== 0 || o_buserr !== 1'b1 || o_cyc !== 1'b0)
            begin $display("FAIL err_after: got nerr=%0d extra_done=%0d buserr=%b cyc=%b want 1,0,1,0",
                           o_nerr, nd, o_buserr, o_cyc); errors++; end
    endtask

    task automatic test_zero_len();
        slave_init();
        start_run(1'b1, 28'h0000500, 16'd0, 32'h0);
        checks++;
        if ({o_done, o_cyc, o_busy, o_buserr} !== 4'b1000 || o_nerr !== 16'd0)
            begin $display("FAIL zero_len: got done=%b cyc=%b busy=%b buserr=%b nerr=%0d want 1,0,0,0,0",
                           o_done, o_cyc, o_busy, o_buserr, o_nerr); errors++; end
        tick();
        checks++;
        if ({o_done, o_cyc} !== 2'b00)
            begin $display("FAIL zero_len_after: got done=%b cyc=%b want 0,0", o_done, o_cyc); errors++; end
    endtask

    task automatic test_addr_wrap();
        int nd;
        slave_init();
        start_run(1'b1, 28'hFFFFFFF, 16'd2, 32'h7);
        checks++;
        if (o_addr !== 28'hFFFFFFF || o_data !== 32'h7)
            begin $display("FAIL wrap_first: got addr=%h data=%h want fffffff,7", o_addr, o_data); errors++; end
        tick();
        checks++;
        if (o_addr !== 28'h0000000 || o_data !== 32'h8)
            begin $display("FAIL wrap_second: got addr=%h data=%h want 0000000,8", o_addr, o_data); errors++; end
        count_done(8, nd);
        checks++;
        if (nd !== 1) begin $display("FAIL wrap_done: got %0d want 1", nd); errors++; end
    endtask

    task automatic test_back_to_back();
        int nd;
        bit seen;
        slave_init();
        start_run(1'b1, 28'h0000600, 16'd4, 32'h0);
        tick();                     // cycle 2: stray start while busy
        i_base = 28'h0000800; i_len = 16'd1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        checks++;
        if (o_addr !== 28'h0000602 || o_busy !== 1'b1)
            begin $display("FAIL busy_start_ignored: got addr=%h busy=%b want 602,1", o_addr, o_busy); errors++; end
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (o_done) seen = 1;
            else tick();
        end
        checks++;
        if (!seen || acc_cnt !== 4)
            begin $display("FAIL busy_run_len: got done_seen=%b accepted=%0d want 1,4", seen, acc_cnt); errors++; end
        // restart in the same cycle o_done is visible
        i_we = 1'b1; i_base = 28'h0000900; i_len = 16'd1; i_seed = 32'h0; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        checks++;
        if (o_cyc !== 1'b1 || o_addr !== 28'h0000900)
            begin $display("FAIL restart_on_done: got cyc=%b addr=%h want 1,900", o_cyc, o_addr); errors++; end
        count_done(6, nd);
        checks++;
        if (nd !== 1) begin $display("FAIL restart_done: got %0d want 1", nd); errors++; end
    endtask

    task automatic test_reset_mid_run();
        int nd;
        slave_init();
        noack = 1'b1;
        start_run(1'b0, 28'h0000A00, 16'd4, 32'h0);
        tick(); tick();             // two accepted, none acked
        rst = 1'b1;
        #1;
        checks++;
        if ({o_busy, o_done, o_nerr, o_buserr, o_cyc, o_stb, o_we, o_addr, o_data, o_sel} !== '0)
            begin $display("FAIL reset_mid_run: got cyc=%b stb=%b busy=%b addr=%h want all 0",
                           o_cyc, o_stb, o_busy, o_addr); errors++; end
        tick(); tick();
        rst = 1'b0;
        noack = 1'b0;
        count_done(4, nd);
        checks++;
        if (nd !== 0 || o_cyc !== 1'b0)
            begin $display("FAIL reset_no_done: got done=%0d cyc=%b want 0,0", nd, o_cyc); errors++; end
        resp_idx = 0;
        start_run(1'b1, 28'h0000B00, 16'd2, 32'h33);
        checks++;
        if (o_cyc !== 1'b1 || o_addr !== 28'h0000B00 || o_data !== 32'h33)
            begin $display("FAIL fresh_first: got cyc=%b addr=%h data=%h want 1,b00,33", o_cyc, o_addr, o_data); errors++; end
        count_done(8, nd);
        checks++;
        if (nd !== 1 || o_nerr !== 16'd0 || o_buserr !== 1'b0)
            begin $display("FAIL fresh_run: got done=%0d nerr=%0d buserr=%b want 1,0,0", nd, o_nerr, o_buserr); errors++; end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_check();
        test_stall();
        test_bus_error();
        test_zero_len();
        test_addr_wrap();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
